// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the IF fetch
// requester and the MEM-stage load/store requester. The data port wins ties
// unless fetch has lost STARVE_MAX decisions in a row. One transaction is in
// flight at a time; every output is registered.
// Optional statistics counters are built when ARB_STATS_EN is defined.
module mem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stat_if_cnt,
  output logic [15:0]       stat_d_cnt,
  output logic [15:0]       stat_conf_cnt
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int LW = $clog2(MEM_LAT + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [LW-1:0] LAT_INIT   = LW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic              owner_if_q, owner_if_d;
  logic              store_q, store_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_gnt_q, if_gnt_d;
  logic              d_gnt_q, d_gnt_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              take_if;

  // Next-state and registered-output logic: arbitration happens only in IDLE,
  // the memory strobe and grant pulse are launched so they appear in ISSUE,
  // and read data is captured on the last WAIT cycle so valid shows in RESP.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    lat_d       = lat_q;
    owner_if_d  = owner_if_q;
    store_d     = store_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    take_if     = if_req && (!d_req || (starve_q == STARVE_LIM));

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          state_d  = ISSUE;
          mem_en_d = 1'b1;
          if (take_if) begin
            owner_if_d  = 1'b1;
            store_d     = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            if_gnt_d    = 1'b1;
          end else begin
            owner_if_d  = 1'b0;
            store_d     = d_we;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            d_gnt_d     = 1'b1;
          end
        end
        // Fetch losing to data bumps the starvation count; any fetch win or
        // absent fetch request wipes it.
        if (!if_req || take_if) begin
          starve_d = '0;
        end else if (d_req && (starve_q != STARVE_LIM)) begin
          starve_d = starve_q + SW'(1);
        end
      end
      ISSUE: begin
        state_d = WAIT;
        lat_d   = LAT_INIT;
      end
      WAIT: begin
        if (lat_q == '0) begin
          state_d = RESP;
          if (owner_if_q) begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end else begin
            d_rdata_d = store_q ? '0 : mem_rdata;
            d_valid_d = 1'b1;
          end
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      lat_q       <= '0;
      owner_if_q  <= 1'b0;
      store_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      lat_q       <= lat_d;
      owner_if_q  <= owner_if_d;
      store_q     <= store_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

`ifdef ARB_STATS_EN
  logic [15:0] stat_if_q, stat_if_d;
  logic [15:0] stat_d_q, stat_d_d;
  logic [15:0] stat_conf_q, stat_conf_d;

  // Saturating counters keyed off the grant decisions made in IDLE.
  always_comb begin
    stat_if_d   = stat_if_q;
    stat_d_d    = stat_d_q;
    stat_conf_d = stat_conf_q;
    if (if_gnt_d && (stat_if_q != 16'hFFFF)) begin
      stat_if_d = stat_if_q + 16'd1;
    end
    if (d_gnt_d && (stat_d_q != 16'hFFFF)) begin
      stat_d_d = stat_d_q + 16'd1;
    end
    if ((state_q == IDLE) && if_req && d_req && (stat_conf_q != 16'hFFFF)) begin
      stat_conf_d = stat_conf_q + 16'd1;
    end
  end

  // Statistics registers, cleared with the rest of the arbiter.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_if_q   <= '0;
      stat_d_q    <= '0;
      stat_conf_q <= '0;
    end else begin
      stat_if_q   <= stat_if_d;
      stat_d_q    <= stat_d_d;
      stat_conf_q <= stat_conf_d;
    end
  end

  assign stat_if_cnt   = stat_if_q;
  assign stat_d_cnt    = stat_d_q;
  assign stat_conf_cnt = stat_conf_q;
`else
  assign stat_if_cnt   = '0;
  assign stat_d_cnt    = '0;
  assign stat_conf_cnt = '0;
`endif

endmodule
